// File: rtl/scoreboard_pkg.sv
// Shared definitions for the register hazard scoreboard.
//   DEFAULT_LAT_W : default latency-counter width (max issue latency 2**W - 1)
//   LAT_ALU/LAT_LOAD/LAT_FPU : issue latencies of the execution units
//   rw(nreg)      : register-index width for a file of nreg registers
package scoreboard_pkg;

  localparam int unsigned DEFAULT_LAT_W = 3;

  localparam int unsigned LAT_ALU  = 1;
  localparam int unsigned LAT_LOAD = 2;
  localparam int unsigned LAT_FPU  = 4;

  function automatic int unsigned rw(input int unsigned nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// One scoreboard counter: cycles until the register's pending result is forwardable.
//   clk, rstn : clock, synchronous active-low reset
//   load      : start tracking a new write; load_val is loaded as-is (no decrement)
//   load_val  : effective latency minus one
//   cnt       : current counter value
//   busy      : counter is non-zero
module scoreboard_entry
  import scoreboard_pkg::*;
#(
  parameter int unsigned LAT_W = DEFAULT_LAT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt,
  output logic             busy
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  // A new issue overrides the running countdown; otherwise count down to 0 and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard deciding whether the instruction in ID may issue.
//   clk, rstn         : clock, synchronous active-low reset
//   issue_valid       : instruction in ID requests issue
//   issue_rs1/rs2     : source indices, qualified by issue_use_rs1/rs2
//   issue_regwrite/rd : destination write enable and index
//   issue_lat         : cycles until the result is forwardable (0 behaves as 1)
//   flush             : kill the instruction in ID this cycle
//   stall             : combinational, issue must be held this cycle
//   busy              : per-register pending flag
//   inflight          : number of pending registers
module hazard_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int unsigned NREG     = 32,
  parameter int unsigned LAT_W    = DEFAULT_LAT_W,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned RW      = rw(NREG),
  localparam int unsigned CW      = $clog2(NREG + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             issue_valid,
  input  logic [RW-1:0]    issue_rs1,
  input  logic [RW-1:0]    issue_rs2,
  input  logic             issue_use_rs1,
  input  logic             issue_use_rs2,
  input  logic             issue_regwrite,
  input  logic [RW-1:0]    issue_rd,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             flush,
  output logic             stall,
  output logic [NREG-1:0]  busy,
  output logic [CW-1:0]    inflight
);

  logic [LAT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  load;
  logic [LAT_W-1:0] eff_m1;
  logic             raw1, raw2, waw, accept;

  // eff_lat - 1, with a requested latency of 0 treated as 1.
  always_comb begin
    eff_m1 = '0;
    if (issue_lat != '0) begin
      eff_m1 = issue_lat - LAT_W'(1);
    end
  end

  // The issuing instruction's own rd is never compared against its sources.
  // A hard-wired zero register is never loaded, so its counter is always 0 and
  // it cannot contribute to any of these terms.
  always_comb begin
    raw1   = issue_use_rs1 && (cnt[issue_rs1] != '0);
    raw2   = issue_use_rs2 && (cnt[issue_rs2] != '0);
    // Younger write must not complete before an older write to the same register.
    waw    = issue_regwrite && (cnt[issue_rd] > eff_m1);
    stall  = issue_valid && (raw1 || raw2 || waw);
    accept = issue_valid && !stall && !flush;
  end

  for (genvar i = 0; i < NREG; i++) begin : g_entry
    localparam bit Tied = ZERO_REG && (i == 0);

    assign load[i] = !Tied && accept && issue_regwrite && (issue_rd == RW'(i));

    scoreboard_entry #(
      .LAT_W(LAT_W)
    ) u_entry (
      .clk     (clk),
      .rstn    (rstn),
      .load    (load[i]),
      .load_val(eff_m1),
      .cnt     (cnt[i]),
      .busy    (busy[i])
    );
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < NREG; i++) begin
      inflight = inflight + CW'(busy[i]);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk;
  logic        rstn;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_use_rs1, issue_use_rs2, issue_regwrite;
  logic [2:0]  issue_lat;
  logic        flush;
  logic        stall, stall_z0;
  logic [31:0] busy, busy_z0;
  logic [5:0]  inflight, inflight_z0;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_scoreboard #(
    .NREG(32), .LAT_W(3), .ZERO_REG(1'b1)
  ) dut (
    .clk(clk), .rstn(rstn), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_regwrite(issue_regwrite), .issue_rd(issue_rd), .issue_lat(issue_lat),
    .flush(flush), .stall(stall), .busy(busy), .inflight(inflight)
  );

  // Same stimulus, register 0 tracked like any other (FP file).
  hazard_scoreboard #(
    .NREG(32), .LAT_W(3), .ZERO_REG(1'b0)
  ) dut_z0 (
    .clk(clk), .rstn(rstn), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_regwrite(issue_regwrite), .issue_rd(issue_rd), .issue_lat(issue_lat),
    .flush(flush), .stall(stall_z0), .busy(busy_z0), .inflight(inflight_z0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2;
    logic        u1, u2, w;
    logic [4:0]  rd;
    logic [2:0]  lat;
    logic        fl;
    logic        e_stall;
    logic [31:0] e_busy;
    logic [5:0]  e_inf;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic w,
                              input logic [4:0] rd, input logic [2:0] lat, input logic fl,
                              input logic es, input logic [31:0] eb, input logic [5:0] ei);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.w = w;
    r.rd = rd; r.lat = lat; r.fl = fl; r.e_stall = es; r.e_busy = eb; r.e_inf = ei;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic w,
                       input logic [4:0] rd, input logic [2:0] lat, input logic fl);
    issue_valid = v; issue_rs1 = rs1; issue_rs2 = rs2;
    issue_use_rs1 = u1; issue_use_rs2 = u2; issue_regwrite = w;
    issue_rd = rd; issue_lat = lat; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[19];
  logic [5:0] exp_inf [13];

  initial begin
    int n;
    exp_inf = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0, 6'd0};

    //            v  rs1 rs2 u1 u2 w  rd  lat fl  stall busy        inflight
    tbl[0]  = mk(1, 5,  0,  1, 0, 0, 0,  0,  0,  0, 32'h0,        6'd0); // just out of reset
    tbl[1]  = mk(1, 0,  0,  0, 0, 1, 3,  2,  0,  0, 32'h0,        6'd0); // load to r3
    tbl[2]  = mk(1, 3,  0,  1, 0, 0, 0,  0,  0,  1, 32'h1 << 3,   6'd1); // load-use bubble
    tbl[3]  = mk(1, 3,  0,  1, 0, 0, 0,  0,  0,  0, 32'h0,        6'd0); // issues
    tbl[4]  = mk(1, 0,  0,  0, 0, 1, 3,  1,  0,  0, 32'h0,        6'd0); // ALU op to r3
    tbl[5]  = mk(1, 3,  0,  1, 0, 0, 0,  0,  0,  0, 32'h0,        6'd0); // back-to-back
    tbl[6]  = mk(1, 0,  0,  0, 0, 1, 9,  4,  1,  0, 32'h0,        6'd0); // flushed write
    tbl[7]  = mk(0, 0,  0,  0, 0, 0, 0,  0,  0,  0, 32'h0,        6'd0); // r9 not pending
    tbl[8]  = mk(1, 0,  0,  0, 0, 1, 4,  2,  0,  0, 32'h0,        6'd0); // r4 cnt -> 1
    tbl[9]  = mk(1, 0,  0,  0, 0, 1, 4,  3,  0,  0, 32'h1 << 4,   6'd1); // reload while decr
    tbl[10] = mk(1, 4,  0,  1, 0, 0, 0,  0,  0,  1, 32'h1 << 4,   6'd1); // cnt4 = 2
    tbl[11] = mk(1, 4,  0,  1, 0, 0, 0,  0,  0,  1, 32'h1 << 4,   6'd1); // cnt4 = 1
    tbl[12] = mk(1, 4,  0,  1, 0, 0, 0,  0,  0,  0, 32'h0,        6'd0); // cnt4 = 0
    tbl[13] = mk(1, 0,  0,  0, 0, 1, 10, 3,  0,  0, 32'h0,        6'd0); // r10 cnt -> 2
    tbl[14] = mk(1, 0,  10, 0, 0, 0, 0,  0,  0,  0, 32'h1 << 10,  6'd1); // rs2 not used
    tbl[15] = mk(1, 0,  10, 0, 1, 0, 0,  0,  0,  1, 32'h1 << 10,  6'd1); // RAW on rs2
    tbl[16] = mk(1, 0,  10, 0, 1, 0, 0,  0,  0,  0, 32'h0,        6'd0);
    tbl[17] = mk(1, 0,  0,  0, 0, 1, 20, 0,  0,  0, 32'h0,        6'd0); // lat 0 acts as 1
    tbl[18] = mk(1, 20, 0,  1, 0, 0, 0,  0,  0,  0, 32'h0,        6'd0);

    rstn = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].w,
            tbl[i].rd, tbl[i].lat, tbl[i].fl);
      @(negedge clk);
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      check($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      check($sformatf("vec%0d_inflight", i), 32'(inflight), 32'(tbl[i].e_inf));
      next_cycle();
    end

    // WAW: r7 lat 6 (cnt 5), then r7 lat 2 holds while cnt7 > 1 -> 4 stall cycles.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 3'd6, 1'b0);
    @(negedge clk);
    check("waw_first_stall", 32'(stall), 32'd0);
    next_cycle();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 3'd2, 1'b0);
    n = 0;
    @(negedge clk);
    while (stall && n < 10) begin
      check("waw_busy7_stalled", 32'(busy[7]), 32'd1);
      n++;
      next_cycle();
      @(negedge clk);
    end
    check("waw_stall_cycles", 32'(n), 32'd4);
    check("waw_busy7_accept", 32'(busy[7]), 32'd1);
    next_cycle();
    idle();
    @(negedge clk);
    check("waw_busy7_after", 32'(busy[7]), 32'd1);
    next_cycle();
    @(negedge clk);
    check("waw_busy7_clear", 32'(busy[7]), 32'd0);
    next_cycle();

    // Zero register: hard-wired in dut, tracked in dut_z0 (lat 5 -> 4 stall cycles).
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 3'd5, 1'b0);
    @(negedge clk);
    check("zero_write_stall", 32'(stall), 32'd0);
    next_cycle();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0);
    @(negedge clk);
    check("zero_busy0", 32'(busy[0]), 32'd0);
    check("zero_busy0_tracked", 32'(busy_z0[0]), 32'd1);
    n = 0;
    while (stall_z0 && n < 10) begin
      check("zero_read_stall", 32'(stall), 32'd0);
      n++;
      next_cycle();
      @(negedge clk);
    end
    check("zero_tracked_stall_cycles", 32'(n), 32'd4);
    next_cycle();
    idle();

    // Five lat-7 writes back-to-back, then everything drains and holds at 0.
    for (int j = 0; j < 13; j++) begin
      if (j < 5) begin
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'(11 + j), 3'd7, 1'b0);
      end else begin
        idle();
      end
      @(negedge clk);
      check($sformatf("sat_inflight_c%0d", j), 32'(inflight), 32'(exp_inf[j]));
      if (j >= 11) check($sformatf("sat_busy_c%0d", j), busy, 32'h0);
      next_cycle();
    end

    // Reset in the middle of a pending write drops it.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd2, 3'd7, 1'b0);
    next_cycle();
    idle();
    rstn = 1'b0;
    @(negedge clk);
    check("midreset_busy2_before", 32'(busy[2]), 32'd1);
    next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    check("midreset_busy", busy, 32'h0);
    check("midreset_inflight", 32'(inflight), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
